// File: rtl/fir_lp_mc.sv
// fir_lp_mc: time-multiplexed multi-channel FIR low-pass filter.
//   One multiply-accumulate per cycle. A sample takes TAPS+2 cycles from acceptance to the
//   output strobe. Coefficients are shared by all channels and can be rewritten while idle.
//   Each channel keeps its own delay line.
// Ports:
//   sys_clk, sys_rst          clock, asynchronous active-high reset
//   din, din_ch, din_vld      input sample, its channel, valid
//   din_rdy                   ready to accept a sample (idle and no coefficient write)
//   coef_wr_en/addr/wdata     coefficient write port, honoured only while idle
//   fir_out, fir_out_ch       rounded, saturated result and its channel (held until next result)
//   fir_out_en                one-cycle result strobe
//   sat_flag                  result was clipped, qualified by fir_out_en
module fir_lp_mc #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned COEF_W = 12,
   parameter int unsigned TAPS   = 16,
   parameter int unsigned CH     = 2,
   parameter int unsigned OUT_W  = 13,
   parameter int unsigned SHIFT  = 10,
   localparam int unsigned CH_W   = (CH > 1) ? $clog2(CH) : 1,
   localparam int unsigned ADDR_W = (TAPS > 1) ? $clog2(TAPS) : 1
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   input  logic signed [DATA_W-1:0] din,
   input  logic        [CH_W-1:0]   din_ch,
   input  logic                     din_vld,
   output logic                     din_rdy,
   input  logic                     coef_wr_en,
   input  logic        [ADDR_W-1:0] coef_addr,
   input  logic signed [COEF_W-1:0] coef_wdata,
   output logic signed [OUT_W-1:0]  fir_out,
   output logic        [CH_W-1:0]   fir_out_ch,
   output logic                     fir_out_en,
   output logic                     sat_flag
);

   localparam int unsigned PROD_W = DATA_W + COEF_W;
   localparam int unsigned ACC_W  = PROD_W + $clog2(TAPS);
   // One extra bit so adding the rounding constant can never wrap.
   localparam int unsigned RND_W  = ACC_W + 1;

   localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1) << SHIFT;
   localparam logic signed [RND_W-1:0]  RND_HALF = RND_W'(1) << (SHIFT - 1);
   localparam logic signed [RND_W-1:0]  OUT_MAX  = RND_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [RND_W-1:0]  OUT_MIN  = ~OUT_MAX;

   typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

   state_e                    state_q, state_d;
   logic        [CH_W-1:0]    ch_q, ch_d;
   logic        [ADDR_W-1:0]  k_q, k_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic signed [COEF_W-1:0]  coef_q [TAPS];
   logic signed [COEF_W-1:0]  coef_d [TAPS];
   logic signed [DATA_W-1:0]  dl_q [CH][TAPS];
   logic signed [DATA_W-1:0]  dl_d [CH][TAPS];
   logic signed [OUT_W-1:0]   fir_out_q, fir_out_d;
   logic        [CH_W-1:0]    fir_out_ch_q, fir_out_ch_d;
   logic                      fir_out_en_q, fir_out_en_d;
   logic                      sat_q, sat_d;

   logic signed [PROD_W-1:0]  prod;
   logic signed [RND_W-1:0]   rnd;
   logic signed [RND_W-1:0]   shr;

   assign din_rdy = (state_q == StIdle) & ~coef_wr_en;

   always_comb begin
      state_d      = state_q;
      ch_d         = ch_q;
      k_d          = k_q;
      acc_d        = acc_q;
      coef_d       = coef_q;
      dl_d         = dl_q;
      fir_out_d    = fir_out_q;
      fir_out_ch_d = fir_out_ch_q;
      fir_out_en_d = 1'b0;
      sat_d        = sat_q;

      prod = dl_q[ch_q][k_q] * coef_q[k_q];
      rnd  = {acc_q[ACC_W-1], acc_q} + RND_HALF;
      shr  = rnd >>> SHIFT;

      unique case (state_q)
         StIdle: begin
            // A coefficient write wins the cycle; din waits.
            if (coef_wr_en) begin
               if (32'(coef_addr) < TAPS) begin
                  coef_d[coef_addr] = coef_wdata;
               end
            end else if (din_vld && (32'(din_ch) < CH)) begin
               for (int t = TAPS - 1; t > 0; t--) begin
                  dl_d[din_ch][t] = dl_q[din_ch][t-1];
               end
               dl_d[din_ch][0] = din;
               ch_d    = din_ch;
               acc_d   = '0;
               k_d     = '0;
               state_d = StMac;
            end
         end
         StMac: begin
            acc_d = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
            k_d   = k_q + ADDR_W'(1);
            if (k_q == ADDR_W'(TAPS - 1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            fir_out_en_d = 1'b1;
            fir_out_ch_d = ch_q;
            if (shr > OUT_MAX) begin
               fir_out_d = OUT_MAX[OUT_W-1:0];
               sat_d     = 1'b1;
            end else if (shr < OUT_MIN) begin
               fir_out_d = OUT_MIN[OUT_W-1:0];
               sat_d     = 1'b1;
            end else begin
               fir_out_d = shr[OUT_W-1:0];
               sat_d     = 1'b0;
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q      <= StIdle;
         ch_q         <= '0;
         k_q          <= '0;
         acc_q        <= '0;
         for (int i = 0; i < TAPS; i++) begin
            coef_q[i] <= (i == 0) ? COEF_ONE : '0;
         end
         for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < TAPS; i++) begin
               dl_q[c][i] <= '0;
            end
         end
         fir_out_q    <= '0;
         fir_out_ch_q <= '0;
         fir_out_en_q <= 1'b0;
         sat_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         k_q          <= k_d;
         acc_q        <= acc_d;
         coef_q       <= coef_d;
         dl_q         <= dl_d;
         fir_out_q    <= fir_out_d;
         fir_out_ch_q <= fir_out_ch_d;
         fir_out_en_q <= fir_out_en_d;
         sat_q        <= sat_d;
      end
   end

   assign fir_out    = fir_out_q;
   assign fir_out_ch = fir_out_ch_q;
   assign fir_out_en = fir_out_en_q;
   assign sat_flag   = sat_q;

endmodule
